// File: rtl/fetch_unit.sv
// fetch_unit: credit-limited in-order instruction fetch with a response FIFO and redirect flush.
// Optional FETCH_ALIGN_CHECK_EN adds fetchFault_o and a sticky FAULT state on misaligned redirects.
module fetch_unit #(
  parameter int instructionWidth = 32,
  parameter int addressSize = 64,
  parameter int bufferDepth = 4,
  parameter int bufferIndexWidth = 2,
  parameter logic [addressSize-1:0] resetAddress = 64'h100
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  input  logic                        enable_i,
  output logic                        memReqValid_o,
  input  logic                        memReqReady_i,
  output logic [addressSize-1:0]      memReqAddress_o,
  input  logic                        memRespValid_i,
  input  logic [instructionWidth-1:0] memRespData_i,
  input  logic                        redirect_i,
  input  logic [addressSize-1:0]      redirectAddress_i,
  output logic [instructionWidth-1:0] instruction_o,
  output logic [addressSize-1:0]      instructionAddress_o,
  output logic                        instructionValid_o,
  input  logic                        decodeStall_i
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic                        fetchFault_o
`endif
);
  localparam int CW = bufferIndexWidth + 1;
  localparam logic [CW:0] DEPTH = (CW + 1)'(bufferDepth);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam logic [1:0] FAULT = 2'd2;
`endif
  logic [1:0] state, next_state;
  logic [addressSize-1:0] fetch_pc, resp_pc, redirect_pc;
  logic [instructionWidth-1:0] data_q [bufferDepth];
  logic [addressSize-1:0] addr_q [bufferDepth];
  logic [CW-1:0] wr_ptr, rd_ptr, occupancy, outstanding, drop_count, resp_dec;
  logic req_fire, push, pop, empty, full, misaligned;
  assign occupancy = wr_ptr - rd_ptr;
  assign empty = occupancy == '0;
  assign full = occupancy == DEPTH[CW-1:0];
  assign memReqValid_o = state == RUN && ({1'b0, occupancy} + {1'b0, outstanding}) < DEPTH && !redirect_i;
  assign memReqAddress_o = fetch_pc;
  assign req_fire = memReqValid_o && memReqReady_i;
  assign resp_dec = CW'(memRespValid_i);
  assign push = memRespValid_i && drop_count == '0 && !redirect_i;
  assign pop = !empty && !decodeStall_i && !redirect_i;
  assign instructionValid_o = !empty;
  assign instruction_o = empty ? '0 : data_q[rd_ptr[bufferIndexWidth-1:0]];
  assign instructionAddress_o = empty ? '0 : addr_q[rd_ptr[bufferIndexWidth-1:0]];
`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned = redirect_i && redirectAddress_i[1:0] != 2'b00;
  assign redirect_pc = redirectAddress_i;
  assign fetchFault_o = state == FAULT;
  // FAULT is left only by an aligned redirect; enable is ignored while faulted
  always_comb next_state = state == FAULT ? (redirect_i && !misaligned ? (enable_i ? RUN : IDLE) : FAULT)
                         : misaligned ? FAULT : enable_i ? RUN : IDLE;
`else
  assign misaligned = 1'b0;
  assign redirect_pc = redirectAddress_i & ~addressSize'(3);
  always_comb next_state = enable_i ? RUN : IDLE;
`endif
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state <= IDLE;
      fetch_pc <= resetAddress;
      resp_pc <= resetAddress;
      wr_ptr <= '0;
      rd_ptr <= '0;
      outstanding <= '0;
      drop_count <= '0;
    end else begin
      state <= next_state;
      if (redirect_i) begin
        fetch_pc <= redirect_pc;
        resp_pc <= redirect_pc;
        wr_ptr <= '0;
        rd_ptr <= '0;
        outstanding <= outstanding - resp_dec;
        drop_count <= outstanding - resp_dec;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + addressSize'(4);
        if (push) resp_pc <= resp_pc + addressSize'(4);
        if (push) wr_ptr <= wr_ptr + CW'(1);
        if (pop) rd_ptr <= rd_ptr + CW'(1);
        outstanding <= outstanding + CW'(req_fire) - resp_dec;
        if (memRespValid_i && drop_count != '0) drop_count <= drop_count - CW'(1);
      end
    end
  end
  always_ff @(posedge clock_i) begin
    if (push) begin
      data_q[wr_ptr[bufferIndexWidth-1:0]] <= memRespData_i;
      addr_q[wr_ptr[bufferIndexWidth-1:0]] <= resp_pc;
    end
  end
`ifndef SYNTHESIS
  always_ff @(posedge clock_i) if (!reset_i) assert (!(push && full));
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against an epoch-based reference model.
module tb_fetch_unit;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst, en, rdy, resp_v, redir, stall, req_v, ins_v;
  logic [31:0] resp_d, ins;
  logic [63:0] raddr, req_a, ins_a;
`ifdef FETCH_ALIGN_CHECK_EN
  logic fault;
`endif
  fetch_unit dut (
    .clock_i(clk),
    .reset_i(rst),
    .enable_i(en),
    .memReqValid_o(req_v),
    .memReqReady_i(rdy),
    .memReqAddress_o(req_a),
    .memRespValid_i(resp_v),
    .memRespData_i(resp_d),
    .redirect_i(redir),
    .redirectAddress_i(raddr),
    .instruction_o(ins),
    .instructionAddress_o(ins_a),
    .instructionValid_o(ins_v),
    .decodeStall_i(stall)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .fetchFault_o(fault)
`endif
  );
  typedef struct {
    logic [63:0] addr;
    int epoch;
    int due;
  } req_t;
  req_t pending[$];
  logic [63:0] expq[$];
  logic [63:0] m_pc;
  bit m_run, m_fault, e_req;
  int epoch, cyc, lat_lo, lat_hi, vectors, errors;
  function automatic logic [31:0] word_of(input logic [63:0] a);
    return {a[15:0], ~a[17:2]} ^ a[63:32];
  endfunction
  // Drive the memory response for this cycle and compute the expected request valid, then go to negedge
  task automatic settle();
    resp_v = 0;
    resp_d = '0;
    if (!rst && pending.size() > 0 && pending[0].due <= cyc) begin
      resp_v = 1;
      resp_d = word_of(pending[0].addr);
    end
    e_req = !rst && m_run && !m_fault && (expq.size() + pending.size() < 4) && !redir;
    @(negedge clk);
  endtask
  // Responses tagged with an older epoch are the stale ones a redirect must discard
  task automatic tick();
    req_t r, n;
    bit keep;
    @(posedge clk);
    if (rst) begin
      pending.delete();
      expq.delete();
      m_pc = 64'h100;
      m_run = 0;
      m_fault = 0;
      epoch++;
    end else begin
      keep = 0;
      if (resp_v) begin
        r = pending.pop_front();
        keep = r.epoch == epoch && !redir;
      end
      if (redir) begin
        expq.delete();
        epoch++;
`ifdef FETCH_ALIGN_CHECK_EN
        m_fault = raddr[1:0] != 2'b00;
        m_pc = raddr;
`else
        m_pc = {raddr[63:2], 2'b00};
`endif
      end else begin
        if (expq.size() > 0 && !stall) void'(expq.pop_front());
        if (keep) expq.push_back(r.addr);
        if (e_req && rdy) begin
          n.addr = m_pc;
          n.epoch = epoch;
          n.due = cyc + int'($urandom_range(lat_hi, lat_lo));
          pending.push_back(n);
          m_pc += 4;
        end
      end
      m_run = en;
    end
    cyc++;
    #1;
  endtask
  task automatic do_reset(input int lo, input int hi);
    lat_lo = lo;
    lat_hi = hi;
    rst = 1; en = 0; rdy = 0; stall = 0; redir = 0; raddr = '0;
    repeat (2) begin
      settle();
      tick();
    end
    rst = 0;
  endtask
  task automatic test_reset();
    do_reset(1, 1);
    settle();
    vectors++; if (req_v !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", req_v); end
    vectors++; if (ins_v !== 1'b0) begin errors++; $display("FAIL reset_ins_valid: got %b want 0", ins_v); end
    vectors++; if (ins !== 32'h0) begin errors++; $display("FAIL reset_ins: got %h want 0", ins); end
    vectors++; if (ins_a !== 64'h0) begin errors++; $display("FAIL reset_ins_addr: got %h want 0", ins_a); end
    tick();
  endtask
  task automatic test_sequential();
    int nreq, first_req, first_v, last;
    logic [63:0] first_a;
    do_reset(1, 1);
    en = 1; rdy = 1;
    nreq = 0; first_req = -1; first_v = -1; last = -1; first_a = '0;
    for (int i = 0; i < 12; i++) begin
      settle();
      if (req_v && rdy && nreq < 3) begin
        vectors++;
        if (req_a !== 64'h100 + 64'(4 * nreq) || (nreq > 0 && cyc != last + 1)) begin
          errors++; $display("FAIL seq_req%0d: got %h at cycle %0d want %h at cycle %0d", nreq, req_a, cyc, 64'h100 + 64'(4 * nreq), last + 1);
        end
        if (nreq == 0) first_req = cyc;
        last = cyc;
        nreq++;
      end
      if (ins_v && first_v < 0) begin
        first_v = cyc;
        first_a = ins_a;
      end
      tick();
    end
    vectors++; if (nreq != 3) begin errors++; $display("FAIL seq_count: got %0d want 3", nreq); end
    vectors++; if (first_v != first_req + 2 || first_a !== 64'h100) begin
      errors++; $display("FAIL seq_first_valid: got cycle %0d addr %h want cycle %0d addr 100", first_v, first_a, first_req + 2);
    end
  endtask
  task automatic test_stall();
    int nreq;
    logic [63:0] popped[$];
    logic [63:0] next_req;
    do_reset(1, 1);
    en = 1; rdy = 1; stall = 1;
    nreq = 0;
    for (int i = 0; i < 12; i++) begin
      settle();
      if (req_v && rdy) nreq++;
      tick();
    end
    vectors++; if (nreq != 4) begin errors++; $display("FAIL stall_credit: got %0d requests want 4", nreq); end
    stall = 0;
    next_req = '1;
    for (int i = 0; i < 12; i++) begin
      settle();
      if (ins_v && !stall) begin
        popped.push_back(ins_a);
        vectors++; if (ins !== word_of(ins_a)) begin errors++; $display("FAIL stall_data: got %h want %h", ins, word_of(ins_a)); end
      end
      if (req_v && rdy && next_req === '1) next_req = req_a;
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (popped.size() <= i || popped[i] !== 64'h100 + 64'(4 * i)) begin
        errors++; $display("FAIL stall_order%0d: got %h want %h", i, popped.size() > i ? popped[i] : 64'hx, 64'h100 + 64'(4 * i));
      end
    end
    vectors++; if (next_req !== 64'h110) begin errors++; $display("FAIL stall_resume: got %h want 110", next_req); end
  endtask
  task automatic test_redirect();
    int nreq;
    logic [63:0] first_a, first_req;
    do_reset(3, 3);
    en = 1; rdy = 1;
    nreq = 0;
    for (int i = 0; i < 10 && nreq < 2; i++) begin
      settle();
      if (req_v && rdy) nreq++;
      tick();
    end
    redir = 1; raddr = 64'h2000;
    settle();
    vectors++; if (req_v !== 1'b0) begin errors++; $display("FAIL redir_no_req: got %b want 0", req_v); end
    tick();
    redir = 0;
    first_a = '1; first_req = '1;
    for (int i = 0; i < 15; i++) begin
      settle();
      if (i == 0) begin
        vectors++; if (ins_v !== 1'b0) begin errors++; $display("FAIL redir_flush: got %b want 0", ins_v); end
      end
      if (req_v && rdy && first_req === '1) first_req = req_a;
      if (ins_v && first_a === '1) first_a = ins_a;
      tick();
    end
    vectors++; if (first_req !== 64'h2000) begin errors++; $display("FAIL redir_req: got %h want 2000", first_req); end
    vectors++; if (first_a !== 64'h2000) begin errors++; $display("FAIL redir_first_ins: got %h want 2000", first_a); end
  endtask
  task automatic test_ready_hold();
    do_reset(1, 1);
    en = 1;
    settle();
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) rdy = 1;
      settle();
      vectors++; if (req_v !== 1'b1 || req_a !== 64'h100) begin
        errors++; $display("FAIL hold%0d: got v=%b a=%h want v=1 a=100", i, req_v, req_a);
      end
      tick();
    end
    settle();
    vectors++; if (req_v !== 1'b1 || req_a !== 64'h104) begin errors++; $display("FAIL hold_next: got v=%b a=%h want v=1 a=104", req_v, req_a); end
    tick();
  endtask
  task automatic test_enable_drop();
    logic [63:0] got[$];
    do_reset(3, 3);
    en = 1; rdy = 1;
    settle(); tick();
    settle(); tick();
    en = 0;
    settle(); tick();
    for (int i = 0; i < 8; i++) begin
      settle();
      vectors++; if (req_v !== 1'b0) begin errors++; $display("FAIL en_idle_req%0d: got %b want 0", i, req_v); end
      if (ins_v && !stall) got.push_back(ins_a);
      tick();
    end
    vectors++; if (got.size() != 2 || got[0] !== 64'h100 || got[1] !== 64'h104) begin
      errors++; $display("FAIL en_delivered: got %0d instrs want 2 (100,104)", got.size());
    end
    en = 1;
    settle(); tick();
    settle();
    vectors++; if (req_v !== 1'b1 || req_a !== 64'h108) begin errors++; $display("FAIL en_resume: got v=%b a=%h want v=1 a=108", req_v, req_a); end
    tick();
  endtask
  task automatic test_misaligned();
    logic [63:0] first_a;
    do_reset(1, 1);
    en = 1; rdy = 1;
    repeat (4) begin settle(); tick(); end
    redir = 1; raddr = 64'h2002;
    settle(); tick();
    redir = 0;
`ifdef FETCH_ALIGN_CHECK_EN
    for (int i = 0; i < 5; i++) begin
      settle();
      vectors++; if (fault !== 1'b1 || req_v !== 1'b0) begin errors++; $display("FAIL fault_hold%0d: got fault=%b v=%b want 1 0", i, fault, req_v); end
      tick();
    end
    redir = 1; raddr = 64'h3000;
    settle(); tick();
    redir = 0;
    settle();
    vectors++; if (fault !== 1'b0 || req_v !== 1'b1 || req_a !== 64'h3000) begin
      errors++; $display("FAIL fault_exit: got fault=%b v=%b a=%h want 0 1 3000", fault, req_v, req_a);
    end
    tick();
`else
    settle();
    vectors++; if (req_v !== 1'b1 || req_a !== 64'h2000) begin errors++; $display("FAIL mask_req: got v=%b a=%h want v=1 a=2000", req_v, req_a); end
    tick();
    first_a = '1;
    for (int i = 0; i < 10; i++) begin
      settle();
      if (ins_v && first_a === '1) first_a = ins_a;
      tick();
    end
    vectors++; if (first_a !== 64'h2000) begin errors++; $display("FAIL mask_ins: got %h want 2000", first_a); end
`endif
  endtask
  task automatic test_random_traffic();
    do_reset(1, 4);
    en = 1; rdy = 1;
    redir = 1; raddr = 64'hFFFF_FFFF_FFFF_FFF0;
    settle(); tick();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(599, 0) == 0) begin
        rst = 1; redir = 0;
        settle(); tick();
        rst = 0;
        continue;
      end
      en = $urandom_range(9, 0) != 0;
      rdy = $urandom_range(3, 0) != 0;
      stall = $urandom_range(2, 0) == 0;
      redir = $urandom_range(39, 0) == 0;
      raddr = {$urandom, $urandom};
      if ($urandom_range(3, 0) != 0) raddr[1:0] = 2'b00;
      settle();
      vectors++; if (req_v !== e_req || (e_req && req_a !== m_pc)) begin
        errors++; $display("FAIL rand_req@%0d: got v=%b a=%h want v=%b a=%h", cyc, req_v, req_a, e_req, m_pc);
      end
      vectors++; if (ins_v !== (expq.size() > 0) || (expq.size() > 0 && (ins_a !== expq[0] || ins !== word_of(expq[0])))) begin
        errors++; $display("FAIL rand_ins@%0d: got v=%b a=%h d=%h want v=%b a=%h", cyc, ins_v, ins_a, ins, expq.size() > 0, expq.size() > 0 ? expq[0] : 64'h0);
      end
`ifdef FETCH_ALIGN_CHECK_EN
      vectors++; if (fault !== m_fault) begin errors++; $display("FAIL rand_fault@%0d: got %b want %b", cyc, fault, m_fault); end
`endif
      tick();
    end
    redir = 0;
  endtask
  initial begin
    vectors = 0; errors = 0; cyc = 0; epoch = 0;
    m_pc = 64'h100; m_run = 0; m_fault = 0;
    resp_v = 0; resp_d = '0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_ready_hold();
    test_enable_drop();
    test_misaligned();
    test_random_traffic();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
